// File: rtl/data_ram_responder_if.sv
// Data-memory port between the core's MEM stage (master) and the data RAM / MMIO responder (slave).
// Signal suffixes are named from the responder's point of view.
interface data_ram_responder_if;
  logic        mem_en_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;

  modport master (
    output mem_en_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
    input  mem_rdata_o
  );

  modport slave (
    input  mem_en_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
    output mem_rdata_o
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-organised RAM plus a small MMIO page holding the LED register,
// synchronised switches, a free-running cycle counter, a timer compare and a sticky match flag.
// Loads are answered combinationally in the same cycle; stores commit on the rising clock edge.
module data_ram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hBFD0_0000,
  parameter int          SW_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_responder_if.slave bus,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic [SW_WIDTH-1:0] led_o,
  output logic                timer_irq_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           ram_q [0:DEPTH-1];

  logic [SW_WIDTH-1:0]   led_q,    led_d;
  logic [31:0]           count_q,  count_d;
  logic [31:0]           cmp_q,    cmp_d;
  logic                  status_q, status_d;
  logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;

  logic                  mmio_hit;
  logic                  rd_en;
  logic                  ram_wr;
  logic                  mmio_wr;
  logic                  match;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [5:0]            mmio_word;
  logic [31:0]           lane_mask;
  logic [31:0]           mmio_rdata;
  logic                  unused_addr_bits;

  // Address decode: the MMIO page is selected by the upper half-word; the byte offset within a word
  // is ignored, and RAM addresses above the array size simply alias onto it.
  assign mmio_hit         = (bus.mem_addr_i[31:16] == MMIO_BASE[31:16]);
  assign ram_idx          = bus.mem_addr_i[ADDR_WIDTH+1:2];
  assign mmio_word        = bus.mem_addr_i[7:2];
  assign rd_en            = bus.mem_en_i & ~bus.mem_we_i;
  assign ram_wr           = bus.mem_en_i & bus.mem_we_i & ~mmio_hit;
  assign mmio_wr          = bus.mem_en_i & bus.mem_we_i & mmio_hit;
  assign lane_mask        = {{8{bus.mem_sel_i[3]}}, {8{bus.mem_sel_i[2]}},
                             {8{bus.mem_sel_i[1]}}, {8{bus.mem_sel_i[0]}}};
  assign match            = (cmp_q != 32'd0) && (count_q == cmp_q);
  assign unused_addr_bits = ^{bus.mem_addr_i[15:8], bus.mem_addr_i[1:0]};

  assign led_o       = led_q;
  assign timer_irq_o = status_q;

  // Store path into the RAM array; only enabled lanes change, and a write seen while reset is
  // asserted is dropped entirely so no partial word is ever committed. The array has no reset.
  always_ff @(posedge clk) begin
    if (ram_wr && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_sel_i[b]) begin
          ram_q[ram_idx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Next state of the MMIO registers: the counter always advances unless a store clears it,
  // and a timer match sets the status flag even if the same cycle tries to clear it.
  always_comb begin
    led_d    = led_q;
    cmp_d    = cmp_q;
    count_d  = count_q + 32'd1;
    status_d = status_q;
    if (mmio_wr) begin
      case (mmio_word)
        6'h00: led_d = (led_q & ~lane_mask[SW_WIDTH-1:0]) |
                       (bus.mem_wdata_i[SW_WIDTH-1:0] & lane_mask[SW_WIDTH-1:0]);
        6'h02: if (bus.mem_sel_i != 4'b0000) count_d = 32'd0;
        6'h03: cmp_d = (cmp_q & ~lane_mask) | (bus.mem_wdata_i & lane_mask);
        6'h04: if (bus.mem_sel_i[0] && bus.mem_wdata_i[0]) status_d = 1'b0;
        default: ;
      endcase
    end
    if (match) begin
      status_d = 1'b1;
    end
  end

  // MMIO register file and the two-flop switch synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      status_q  <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  // MMIO read mux; unmapped offsets read as zero.
  always_comb begin
    mmio_rdata = '0;
    case (mmio_word)
      6'h00: mmio_rdata = 32'(led_q);
      6'h01: mmio_rdata = 32'(sw_sync_q);
      6'h02: mmio_rdata = count_q;
      6'h03: mmio_rdata = cmp_q;
      6'h04: mmio_rdata = {31'd0, status_q};
      default: ;
    endcase
  end

  // Load data goes straight back to MEM in the same cycle; idle, store and reset cycles return zero.
  always_comb begin
    bus.mem_rdata_o = '0;
    if (!rst && rd_en) begin
      bus.mem_rdata_o = mmio_hit ? mmio_rdata : ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: the driver pushes expected load data / LED / IRQ values
// from a register-level reference model, and a negedge monitor pops and compares them.
module tb_data_ram_responder;

  localparam int          AW  = 10;
  localparam logic [31:0] MB  = 32'hBFD0_0000;
  localparam int          SWW = 16;

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;
    string       tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SWW-1:0]  sw_i = '0;
  logic [SWW-1:0]  led_o;
  logic            timer_irq_o;

  int vecCount  = 0;
  int missCount = 0;

  exp_t expQ[$];

  // Reference model state
  logic [31:0] ramM [int];
  logic [15:0] ledM;
  logic [31:0] countM;
  logic [31:0] cmpM;
  logic        statusM;
  logic [15:0] swHist[$];

  logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};

  data_ram_responder_if bus ();

  data_ram_responder #(.ADDR_WIDTH(AW), .MMIO_BASE(MB), .SW_WIDTH(SWW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .sw_i        (sw_i),
    .led_o       (led_o),
    .timer_irq_o (timer_irq_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every cycle the driver has issued gets its outputs compared on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".rdata"}, bus.mem_rdata_o, e.rdata);
      checkOutput({e.tag, ".led"}, 32'(led_o), 32'(e.led));
      checkOutput({e.tag, ".irq"}, 32'(timer_irq_o), 32'(e.irq));
    end
  end

  function automatic logic [31:0] laneMerge(input logic [31:0] oldv, input logic [31:0] newv,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = oldv;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = newv[8*b +: 8];
    return r;
  endfunction

  function automatic logic isMmio(input logic [31:0] a);
    return a[31:16] == MB[31:16];
  endfunction

  function automatic int ramIdx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (isMmio(a)) begin
      case (a[7:0] & 8'hFC)
        8'h00:   return 32'(ledM);
        8'h04:   return 32'(swHist[0]);
        8'h08:   return countM;
        8'h0C:   return cmpM;
        8'h10:   return {31'd0, statusM};
        default: return 32'd0;
      endcase
    end
    return ramM.exists(ramIdx(a)) ? ramM[ramIdx(a)] : 32'd0;
  endfunction

  function automatic void modelReset();
    ledM = '0; countM = '0; cmpM = '0; statusM = 1'b0;
    swHist = '{16'h0, 16'h0};
  endfunction

  // One clock edge of the reference model, applied after the transaction of that cycle
  function automatic void modelStep(input logic en, input logic we, input logic [31:0] a,
                                    input logic [3:0] sel, input logic [31:0] wd);
    logic        hit;
    logic [31:0] nextCount;
    hit       = (cmpM != 0) && (countM == cmpM);
    nextCount = countM + 32'd1;
    if (en && we) begin
      if (isMmio(a)) begin
        case (a[7:0] & 8'hFC)
          8'h00: ledM = laneMerge(32'(ledM), wd, sel)[15:0];
          8'h08: if (sel != 4'b0000) nextCount = 32'd0;
          8'h0C: cmpM = laneMerge(cmpM, wd, sel);
          8'h10: if (sel[0] && wd[0]) statusM = 1'b0;
          default: ;
        endcase
      end else begin
        ramM[ramIdx(a)] = laneMerge(ramM.exists(ramIdx(a)) ? ramM[ramIdx(a)] : 32'd0, wd, sel);
      end
    end
    if (hit) statusM = 1'b1;
    countM = nextCount;
    void'(swHist.pop_front());
    swHist.push_back(sw_i);
  endfunction

  // Drive one bus cycle, record what the outputs must show during it, then advance past the edge
  task automatic applyStimulus(input logic en, input logic we, input logic [31:0] a,
                               input logic [3:0] sel, input logic [31:0] wd, input string tag);
    exp_t e;
    bus.mem_en_i    = en;
    bus.mem_we_i    = we;
    bus.mem_addr_i  = a;
    bus.mem_sel_i   = sel;
    bus.mem_wdata_i = wd;
    e.rdata = (en && !we) ? modelRead(a) : 32'd0;
    e.led   = ledM;
    e.irq   = statusM;
    e.tag   = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    modelStep(en, we, a, sel, wd);
    bus.mem_en_i = 1'b0;
    bus.mem_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d, input string tag);
    applyStimulus(1'b1, 1'b1, a, sel, d, tag);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    applyStimulus(1'b1, 1'b0, a, 4'b1111, 32'd0, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0, "idle");
  endtask

  // Assert reset in the middle of a cycle carrying the given access; outputs must clear at once
  // and the access must leave no trace
  task automatic resetMidCycle(input logic en, input logic we, input logic [31:0] a,
                               input logic [3:0] sel, input logic [31:0] wd, input string tag);
    bus.mem_en_i    = en;
    bus.mem_we_i    = we;
    bus.mem_addr_i  = a;
    bus.mem_sel_i   = sel;
    bus.mem_wdata_i = wd;
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, ".rdata"}, bus.mem_rdata_o, 32'd0);
    checkOutput({tag, ".led"}, 32'(led_o), 32'd0);
    checkOutput({tag, ".irq"}, 32'(timer_irq_o), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    bus.mem_en_i = 1'b0;
    bus.mem_we_i = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelStep(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
  endtask

  initial begin
    bus.mem_en_i    = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_sel_i   = '0;
    bus.mem_wdata_i = '0;
    modelReset();
    rst = 1'b1;

    // Power-on reset
    #7;
    checkOutput("por.rdata", bus.mem_rdata_o, 32'd0);
    checkOutput("por.led", 32'(led_o), 32'd0);
    checkOutput("por.irq", 32'(timer_irq_o), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelStep(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
    $display("[TB] reset released");

    // RAM byte lanes, empty strobe and address aliasing
    wr(32'h0000_0100, 4'b1111, 32'h1122_3344, "ram.full");
    wr(32'h0000_0100, 4'b0001, 32'h0000_00AA, "ram.lane0");
    rd(32'h0000_0100, "ram.merged");
    wr(32'h0000_0100, 4'b0000, 32'hDEAD_BEEF, "ram.nosel");
    rd(32'h0000_0100, "ram.unchanged");
    rd(32'h0000_0100 + 4 * (2 ** AW), "ram.alias");
    rd(32'h0000_0103, "ram.byteoff");

    // Store then load on consecutive cycles
    wr(32'h0000_0040, 4'b1111, 32'hCAFE_0001, "rdt.first");
    wr(32'h0000_0040, 4'b1111, 32'hCAFE_0002, "rdt.second");
    rd(32'h0000_0040, "rdt.next");

    // MMIO LED, switch synchroniser and unmapped offset
    wr(MB | 32'h00, 4'b0011, 32'h0000_A5A5, "mmio.led");
    rd(MB | 32'h00, "mmio.ledrd");
    sw_i = 16'h1234;
    rd(MB | 32'h04, "mmio.sw1");
    rd(MB | 32'h04, "mmio.sw2");
    rd(MB | 32'h04, "mmio.sw3");
    rd(MB | 32'h20, "mmio.unmapped");
    wr(MB | 32'h20, 4'b1111, 32'hFFFF_FFFF, "mmio.unmappedwr");
    rd(MB | 32'h20, "mmio.unmapped2");

    // Timer compare, match flag and W1C
    wr(MB | 32'h0C, 4'b1111, 32'd10, "tmr.cmp");
    wr(MB | 32'h08, 4'b1111, 32'd0, "tmr.clr");
    idle(12);
    rd(MB | 32'h10, "tmr.status");
    wr(MB | 32'h10, 4'b0001, 32'd1, "tmr.w1c");
    rd(MB | 32'h10, "tmr.cleared");
    wr(MB | 32'h08, 4'b0100, 32'd0, "tmr.clr2");
    idle(10);
    wr(MB | 32'h10, 4'b0001, 32'd1, "tmr.w1cmatch");
    idle(2);

    // Reset during a load with LED and IRQ set
    resetMidCycle(1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'd0, "rst.read");
    rd(MB | 32'h00, "rst.led");
    rd(32'h0000_0100, "rst.ramkept");

    // CMP of zero never matches
    wr(MB | 32'h08, 4'b1111, 32'd0, "tmr.clr0");
    idle(15);
    rd(MB | 32'h10, "tmr.nomatch");

    // Reset aborting a store
    resetMidCycle(1'b1, 1'b1, 32'h0000_0040, 4'b1111, 32'h0BAD_0BAD, "rst.write");
    rd(32'h0000_0040, "rst.abort");

    // Counter wrap and clear on the wrapping cycle
    force dut.count_q = 32'hFFFF_FFFD;
    #1;
    release dut.count_q;
    countM = 32'hFFFF_FFFD;
    rd(MB | 32'h08, "cnt.fffd");
    rd(MB | 32'h08, "cnt.fffe");
    rd(MB | 32'h08, "cnt.ffff");
    rd(MB | 32'h08, "cnt.wrap");
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    countM = 32'hFFFF_FFFF;
    wr(MB | 32'h08, 4'b0010, 32'd0, "cnt.clrwrap");
    rd(MB | 32'h08, "cnt.after");

    // Randomised traffic over RAM and the MMIO page
    for (int i = 0; i < 16; i++) wr(32'(i) << 2, 4'b1111, $urandom, "rnd.init");
    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        w;
      r = $urandom_range(0, 9);
      s = 4'($urandom);
      w = 1'($urandom);
      d = $urandom;
      if (r <= 3) begin
        a = $urandom;
        a[11:6] = '0;
        if (a[31:16] == MB[31:16]) a[16] = ~a[16];
        if (w) wr(a, s, d, "rnd.ramwr");
        else   rd(a, "rnd.ramrd");
      end else if (r <= 7) begin
        a = {MB[31:16], 8'($urandom), offs[$urandom_range(0, 7)] | 8'($urandom_range(0, 3))};
        if ((a[7:0] & 8'hFC) == 8'h0C) d = 32'($urandom_range(0, 40));
        if (w) wr(a, s, d, "rnd.mmiowr");
        else   rd(a, "rnd.mmiord");
      end else if (r == 8) begin
        idle(1);
      end else begin
        sw_i = 16'($urandom);
        idle(1);
      end
    end
    idle(2);

    checkOutput("queue.drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
